// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control unit.
// Stall request encodings come from the hazard unit; PC state covers multi-cycle holds.
package pipeline_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_t;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard-unit requests in, pipeline register controls and perf counters out.
// master = hazard side / observer, slave = pipeline_control_unit.
interface pipeline_control_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [1:0]           stall_req;
    logic                 flush_req;
    logic                 mispredict;
    logic                 pc_write_en;
    logic                 if_id_write_en;
    logic                 if_id_flush;
    logic                 id_ex_bubble;
    logic                 stalling;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output stall_req, flush_req, mispredict,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               stalling, stall_cycles, mispredict_count
    );

    modport slave (
        input  stall_req, flush_req, mispredict,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               stalling, stall_cycles, mispredict_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end
endmodule

// File: rtl/pipeline_control_unit.sv
// Turns hazard-unit stall/flush/mispredict requests into PC, IF/ID and ID/EX controls,
// stretching 2-cycle stalls through a HOLD state and counting stalls and mispredicts.
module pipeline_control_unit
    import pipeline_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_control_unit_if.slave  bus
);
    pc_state_t  state, state_nx;
    logic       rem, rem_nx;
    logic [1:0] req_len;
    logic       stall_now;
    logic       accept_flush;

    assign req_len      = (bus.stall_req > STALL_TWO) ? STALL_TWO : bus.stall_req;
    assign stall_now    = (state == HOLD) || (req_len != STALL_NONE);
    assign accept_flush = bus.flush_req && !stall_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // A fresh 2-cycle request during HOLD re-arms HOLD so the longest request wins.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        case (state)
            RUN: begin
                if (req_len == STALL_TWO) begin
                    state_nx = HOLD;
                    rem_nx   = 1'b0;
                end
            end
            HOLD: begin
                if (rem || (req_len == STALL_TWO)) begin
                    state_nx = HOLD;
                    rem_nx   = 1'b0;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Flush is masked while stalling: branch resolution in ID would see stale operands.
    always_comb begin
        bus.pc_write_en    = 1'b1;
        bus.if_id_write_en = 1'b1;
        bus.if_id_flush    = 1'b0;
        bus.id_ex_bubble   = 1'b0;
        bus.stalling       = 1'b0;
        if (rst) begin
            bus.pc_write_en    = 1'b0;
            bus.if_id_write_en = 1'b0;
            bus.if_id_flush    = 1'b1;
            bus.id_ex_bubble   = 1'b1;
        end else if (stall_now) begin
            bus.pc_write_en    = 1'b0;
            bus.if_id_write_en = 1'b0;
            bus.id_ex_bubble   = 1'b1;
            bus.stalling       = 1'b1;
        end else if (accept_flush) begin
            bus.if_id_flush    = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_now),
        .count (bus.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mp_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (bus.mispredict && !stall_now),
        .count (bus.mispredict_count)
    );
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Drives a 32-bit and a 4-bit counter instance with the same request stream and
// checks both against a remaining-stall-count reference model.
module tb_pipeline_control_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_control_unit_if #(.CNT_WIDTH(32)) bus  ();
    pipeline_control_unit_if #(.CNT_WIDTH(4))  bus4 ();

    pipeline_control_unit #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pipeline_control_unit #(.CNT_WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // reference model: stall cycles still owed after the current one, plus raw event counts
    int     hold_left;
    longint st_cnt, mp_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input longint max);
        return (v > max) ? 32'(max) : 32'(v);
    endfunction

    task automatic step(input logic r, input logic [1:0] sr, input logic fr, input logic mp);
        int   rl;
        logic stall;
        logic e_pc, e_ifw, e_fl, e_bub, e_stl;
        @(negedge clk);
        rst            = r;
        bus.stall_req  = sr;  bus4.stall_req  = sr;
        bus.flush_req  = fr;  bus4.flush_req  = fr;
        bus.mispredict = mp;  bus4.mispredict = mp;
        #1;
        rl    = (sr > 2'd2) ? 2 : int'(sr);
        stall = (hold_left > 0) || (rl != 0);
        if (r)          {e_pc, e_ifw, e_fl, e_bub, e_stl} = 5'b00110;
        else if (stall) {e_pc, e_ifw, e_fl, e_bub, e_stl} = 5'b00011;
        else if (fr)    {e_pc, e_ifw, e_fl, e_bub, e_stl} = 5'b11100;
        else            {e_pc, e_ifw, e_fl, e_bub, e_stl} = 5'b11000;
        chk("pc_write_en",    32'(bus.pc_write_en),    32'(e_pc));
        chk("if_id_write_en", 32'(bus.if_id_write_en), 32'(e_ifw));
        chk("if_id_flush",    32'(bus.if_id_flush),    32'(e_fl));
        chk("id_ex_bubble",   32'(bus.id_ex_bubble),   32'(e_bub));
        chk("stalling",       32'(bus.stalling),       32'(e_stl));
        chk("stalling_w4",    32'(bus4.stalling),      32'(e_stl));
        chk("stall_cycles",   bus.stall_cycles,        sat(st_cnt, 64'hFFFF_FFFF));
        chk("mispredict_cnt", bus.mispredict_count,    sat(mp_cnt, 64'hFFFF_FFFF));
        chk("stall_cycles_w4",   32'(bus4.stall_cycles),     sat(st_cnt, 15));
        chk("mispredict_cnt_w4", 32'(bus4.mispredict_count), sat(mp_cnt, 15));
        if (r) begin
            hold_left = 0;
            st_cnt    = 0;
            mp_cnt    = 0;
        end else begin
            if (stall)       st_cnt++;
            if (mp && !stall) mp_cnt++;
            hold_left = hold_left - 1;
            if (rl - 1 > hold_left) hold_left = rl - 1;
            if (hold_left < 0)      hold_left = 0;
        end
    endtask

    initial begin
        hold_left = 0; st_cnt = 0; mp_cnt = 0;
        rst = 1'b1;
        bus.stall_req = STALL_NONE; bus.flush_req = 1'b0; bus.mispredict = 1'b0;
        bus4.stall_req = STALL_NONE; bus4.flush_req = 1'b0; bus4.mispredict = 1'b0;

        repeat (3) step(1, 2'd0, 0, 0);
        repeat (2) step(0, 2'd0, 0, 0);

        step(0, STALL_ONE, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("stall1_count", bus.stall_cycles, 32'd1);

        step(0, STALL_TWO, 0, 0);
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("stall2_count", bus.stall_cycles, 32'd3);

        // stall with colliding flush; flush re-asserted once the stall ends
        step(0, STALL_TWO, 1, 1);
        step(0, 2'd0, 1, 0);
        step(0, 2'd0, 1, 1);
        chk("flush_after_stall", 32'(bus.if_id_flush), 32'd1);
        step(0, 2'd0, 0, 0);
        chk("mp_after_stall", bus.mispredict_count, 32'd1);

        step(0, STALL_TWO, 0, 0);
        step(0, STALL_TWO, 0, 0);
        step(0, 2'd3, 0, 0);
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);

        step(0, STALL_TWO, 0, 0);
        step(1, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("post_reset_run", 32'(bus.stalling), 32'd0);

        repeat (20) step(0, STALL_ONE, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("sat_stall_w4", 32'(bus4.stall_cycles), 32'd15);
        repeat (20) step(0, 2'd0, 0, 1);
        step(0, 2'd0, 0, 0);
        chk("sat_mp_w4", 32'(bus4.mispredict_count), 32'd15);

        step(1, 2'd0, 0, 0);
        repeat (600) begin
            step(($urandom_range(0, 49) == 0),
                 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
